// File: rtl/sha256_msg_loader.sv
// Byte-stream front end for sha256_core: loads one padded 64-byte block, starts the core, waits for IRQ.
// Optional digest readback enabled by defining SHA_LOADER_READBACK_EN.
module sha256_msg_loader #(
    parameter int unsigned STATUS_ADDR = 65,
    parameter int unsigned DIGEST_BASE = 70,
    parameter int unsigned MAX_BYTES   = 55,
    parameter int unsigned IRQ_TIMEOUT = 1023
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   i_byte,
    input  logic         i_valid,
    input  logic         i_last,
    output logic         o_ready,
    output logic [6:0]   o_w_addr,
    output logic [7:0]   o_data8,
    output logic         o_we,
    input  logic         i_irq,
    input  logic [7:0]   i_rdata,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [255:0] o_digest,
    output logic         o_digest_valid
);

    localparam int unsigned TW = $clog2(IRQ_TIMEOUT + 1);
    localparam logic [5:0]    LP_MAX    = 6'(MAX_BYTES);
    localparam logic [6:0]    LP_STATUS = 7'(STATUS_ADDR);
    localparam logic [TW-1:0] LP_TMO    = TW'(IRQ_TIMEOUT - 1);

`ifdef SHA_LOADER_READBACK_EN
    localparam logic [6:0] LP_DIGEST = 7'(DIGEST_BASE);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_PAD80, S_ZERO, S_LEN, S_START, S_WAIT, S_DRAIN, S_RDBK
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_PAD80, S_ZERO, S_LEN, S_START, S_WAIT, S_DRAIN
    } state_t;
`endif

    state_t          r_state;
    logic [5:0]      r_cnt;
    logic [5:0]      r_ptr;
    logic [6:0]      r_w_addr;
    logic [7:0]      r_data8;
    logic            r_we;
    logic            r_done;
    logic            r_err;
    logic [TW-1:0]   r_tmo;
    logic [15:0]     w_len;
    logic [7:0]      w_len_byte;
    logic            w_accept;

    assign o_ready  = i_rst_n && (r_state == S_IDLE || r_state == S_LOAD || r_state == S_DRAIN);
    assign o_busy   = (r_state != S_IDLE);
    assign w_accept = i_valid && o_ready;
    assign o_w_addr = r_w_addr;
    assign o_data8  = r_data8;
    assign o_we     = r_we;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign w_len    = {7'b0, r_cnt, 3'b000};

    // Only the two low length bytes can be non-zero for a single-block message.
    always_comb begin
        w_len_byte = 8'h00;
        if (r_ptr == 6'd0)
            w_len_byte = w_len[7:0];
        else if (r_ptr == 6'd1)
            w_len_byte = w_len[15:8];
    end

`ifdef SHA_LOADER_READBACK_EN
    logic [4:0]   r_rb_idx;
    logic [255:0] r_digest;
    logic         r_digest_valid;
    assign o_digest       = r_digest;
    assign o_digest_valid = r_digest_valid;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^i_rdata;
    assign o_digest       = '0;
    assign o_digest_valid = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_w_addr <= '0;
            r_data8  <= '0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
`ifdef SHA_LOADER_READBACK_EN
            r_rb_idx       <= '0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef SHA_LOADER_READBACK_EN
            r_digest_valid <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_w_addr <= 7'd63;
                        r_data8  <= i_byte;
                        r_we     <= 1'b1;
                        r_cnt    <= 6'd1;
                        r_state  <= i_last ? S_PAD80 : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_cnt == LP_MAX) begin
                            if (i_last) begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_w_addr <= 7'd63 - {1'b0, r_cnt};
                            r_data8  <= i_byte;
                            r_we     <= 1'b1;
                            r_cnt    <= r_cnt + 6'd1;
                            if (i_last)
                                r_state <= S_PAD80;
                        end
                    end
                end
                S_PAD80: begin
                    r_w_addr <= 7'd63 - {1'b0, r_cnt};
                    r_data8  <= 8'h80;
                    r_we     <= 1'b1;
                    // For a full 55-byte message this lands on 7, the first length byte.
                    r_ptr    <= 6'd62 - r_cnt;
                    r_state  <= (r_cnt == LP_MAX) ? S_LEN : S_ZERO;
                end
                S_ZERO: begin
                    r_w_addr <= {1'b0, r_ptr};
                    r_data8  <= 8'h00;
                    r_we     <= 1'b1;
                    r_ptr    <= r_ptr - 6'd1;
                    if (r_ptr == 6'd8)
                        r_state <= S_LEN;
                end
                S_LEN: begin
                    r_w_addr <= {1'b0, r_ptr};
                    r_data8  <= w_len_byte;
                    r_we     <= 1'b1;
                    r_ptr    <= r_ptr - 6'd1;
                    if (r_ptr == 6'd0)
                        r_state <= S_START;
                end
                S_START: begin
                    r_w_addr <= LP_STATUS;
                    r_data8  <= 8'h01;
                    r_we     <= 1'b1;
                    r_tmo    <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_irq) begin
`ifdef SHA_LOADER_READBACK_EN
                        r_w_addr <= LP_DIGEST;
                        r_rb_idx <= '0;
                        r_state  <= S_RDBK;
`else
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
`endif
                    end else if (r_tmo == LP_TMO) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && i_last) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
`ifdef SHA_LOADER_READBACK_EN
                S_RDBK: begin
                    // Read data follows the address register combinationally; capture at cycle end.
                    r_digest[{r_rb_idx, 3'b000} +: 8] <= i_rdata;
                    if (r_rb_idx == 5'd31) begin
                        r_digest_valid <= 1'b1;
                        r_done         <= 1'b1;
                        r_state        <= S_IDLE;
                    end else begin
                        r_rb_idx <= r_rb_idx + 5'd1;
                        r_w_addr <= r_w_addr + 7'd1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Directed self-checking bench for sha256_msg_loader with a behavioural core stub.
// Digest readback checks are compiled when SHA_LOADER_READBACK_EN is defined.
module tb_sha256_msg_loader;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [7:0]   i_byte = '0;
    logic         i_valid = 1'b0;
    logic         i_last = 1'b0;
    logic         o_ready;
    logic [6:0]   o_w_addr;
    logic [7:0]   o_data8;
    logic         o_we;
    logic         i_irq = 1'b0;
    logic [7:0]   i_rdata;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic [255:0] o_digest;
    logic         o_digest_valid;

    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mem [0:127];
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0, dv_cnt = 0;
    int cyc = 0, start_cyc = 0, err_cyc = 0, irq_delay = 0;
    logic irq_en = 1'b1;
    logic [7:0] abc_b [0:2] = '{8'h61, 8'h62, 8'h63};

    sha256_msg_loader #(
        .STATUS_ADDR(65),
        .DIGEST_BASE(70),
        .MAX_BYTES(55),
        .IRQ_TIMEOUT(1023)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_byte), .i_valid(i_valid),
        .i_last(i_last), .o_ready(o_ready), .o_w_addr(o_w_addr), .o_data8(o_data8),
        .o_we(o_we), .i_irq(i_irq), .i_rdata(i_rdata), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_digest(o_digest), .o_digest_valid(o_digest_valid)
    );

    always #5 i_clk = ~i_clk;

    // Core stub: digest window returns the known "abc" digest, byte i at DIGEST_BASE+i.
    always_comb begin
        i_rdata = 8'h00;
        if (o_w_addr >= 7'd70 && o_w_addr < 7'd102)
            i_rdata = ABC_DIG[(int'(o_w_addr) - 70) * 8 +: 8];
    end

    always @(negedge i_clk) begin
        i_irq = 1'b0;
        if (!i_rst_n) begin
            irq_delay = 0;
        end else begin
            if (irq_delay > 0) begin
                irq_delay--;
                if (irq_delay == 0) i_irq = 1'b1;
            end
            if (o_we) begin
                mem[o_w_addr] = o_data8;
                wr_cnt++;
                if (o_w_addr == 7'd65) begin
                    start_cyc = cyc;
                    if (irq_en) irq_delay = 4;
                end
            end
            if (o_done) done_cnt++;
            if (o_err) begin err_cnt++; err_cyc = cyc; end
            if (o_digest_valid) dv_cnt++;
        end
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_stub();
        for (int i = 0; i < 128; i++) mem[i] = 8'hEE;
        wr_cnt = 0; done_cnt = 0; err_cnt = 0; dv_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        @(negedge i_clk);
        i_byte = b; i_valid = 1'b1; i_last = last;
        while (!o_ready && n < 500) begin @(negedge i_clk); n++; end
        if (n >= 500) check_eq("accept_timeout", 0, 1);
        @(posedge i_clk);
    endtask

    task automatic end_stream();
        @(negedge i_clk);
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic send_count(input int n);
        for (int k = 0; k < n; k++) send_byte(8'(k), k == n - 1);
        end_stream();
    endtask

    task automatic wait_end(input string tag, input int max);
        int n = 0;
        while (done_cnt + err_cnt == 0 && n < max) begin @(negedge i_clk); n++; end
        if (n >= max) check_eq({tag, "_end_timeout"}, 0, 1);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic run_abc(input string tag);
        int bad = 0;
        clear_stub();
        for (int k = 0; k < 3; k++) send_byte(abc_b[k], k == 2);
        end_stream();
        wait_end(tag, 2000);
        check_eq({tag, "_m63"}, mem[63], 8'h61);
        check_eq({tag, "_m62"}, mem[62], 8'h62);
        check_eq({tag, "_m61"}, mem[61], 8'h63);
        check_eq({tag, "_m60"}, mem[60], 8'h80);
        for (int a = 2; a <= 59; a++) if (mem[a] != 8'h00) bad++;
        check_eq({tag, "_zero_fill"}, bad, 0);
        check_eq({tag, "_m1"}, mem[1], 8'h00);
        check_eq({tag, "_m0"}, mem[0], 8'h18);
        check_eq({tag, "_start"}, mem[65], 8'h01);
        check_eq({tag, "_writes"}, wr_cnt, 65);
        check_eq({tag, "_done"}, done_cnt, 1);
        check_eq({tag, "_err"}, err_cnt, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
`ifdef SHA_LOADER_READBACK_EN
        check_eq({tag, "_digest"}, o_digest, ABC_DIG);
        check_eq({tag, "_dv"}, dv_cnt, 1);
`endif
    endtask

    initial begin
        #2;
        check_eq("rst_we", o_we, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst_ready", o_ready, 0);
        check_eq("rst_digest", o_digest, 0);
        check_eq("rst_dv", o_digest_valid, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_eq("idle_ready", o_ready, 1);

        run_abc("abc");

        // 55 bytes: last data byte at 9, pad at 8, length 440 = 0x1B8.
        clear_stub();
        send_count(55);
        wait_end("b55", 2000);
        check_eq("b55_m63", mem[63], 8'h00);
        check_eq("b55_m9", mem[9], 8'h36);
        check_eq("b55_m8", mem[8], 8'h80);
        check_eq("b55_m2", mem[2], 8'h00);
        check_eq("b55_m1", mem[1], 8'h01);
        check_eq("b55_m0", mem[0], 8'hB8);
        check_eq("b55_writes", wr_cnt, 65);
        check_eq("b55_done", done_cnt, 1);

        clear_stub();
        send_count(56);
        wait_end("b56", 200);
        check_eq("b56_writes", wr_cnt, 55);
        check_eq("b56_no_start", mem[65], 8'hEE);
        check_eq("b56_err", err_cnt, 1);
        check_eq("b56_done", done_cnt, 0);
        check_eq("b56_busy", o_busy, 0);

        run_abc("abc_after56");

        clear_stub();
        send_count(70);
        wait_end("b70", 200);
        check_eq("b70_writes", wr_cnt, 55);
        check_eq("b70_no_start", mem[65], 8'hEE);
        check_eq("b70_m9", mem[9], 8'h36);
        check_eq("b70_err", err_cnt, 1);
        check_eq("b70_busy", o_busy, 0);

        irq_en = 1'b0;
        clear_stub();
        for (int k = 0; k < 3; k++) send_byte(abc_b[k], k == 2);
        end_stream();
        wait_end("tmo", 1500);
        check_eq("tmo_err", err_cnt, 1);
        check_eq("tmo_done", done_cnt, 0);
        check_eq("tmo_delay", err_cyc - start_cyc, 1023);
        check_eq("tmo_busy", o_busy, 0);
        irq_en = 1'b1;

        clear_stub();
        for (int k = 0; k < 3; k++) send_byte(abc_b[k], k == 2);
        end_stream();
        repeat (10) @(negedge i_clk);
        check_eq("mid_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", o_we, 0);
        check_eq("mid_rst_busy", o_busy, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        clear_stub();
        repeat (20) @(negedge i_clk);
        check_eq("mid_no_stale", wr_cnt, 0);
        run_abc("abc_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
